tcb_lite_sub_mem: RTL and testbench

- Synthesizable, parametrised TCB-Lite subordinate: byte-addressed memory with configurable fixed response delay, run-time selectable backpressure generator, error response and transfer/stall/idle statistics counters.
- Used in FPGA/emulation builds and as an RTL-level replacement for the behavioural subordinate model. Sits directly on a TCB-Lite manager or interconnect port.

---
 rtl/tcb_lite_pkg.sv | 27 ++
 rtl/tcb_lite_sub_bpr.sv | 44 ++++
 rtl/tcb_lite_sub_mem.sv | 123 ++++++++++++
 tb/tb_tcb_lite_sub_mem.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcb_lite_pkg.sv
// Shared types and constants for the TCB-Lite subordinate memory and its
// backpressure generator.
package tcb_lite_pkg;

  typedef enum logic [1:0] {
    BPR_RDY   = 2'd0,
    BPR_PAT   = 2'd1,
    BPR_LFSR  = 2'd2,
    BPR_STALL = 2'd3
  } bpr_mode_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Response data is carried at the widest supported bus width and trimmed at the port.
  localparam int RSP_DAT_MAX = 64;

  typedef struct packed {
    logic [RSP_DAT_MAX-1:0] rdt;
    logic                   err;
  } tcb_lite_sub_rsp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/tcb_lite_sub_bpr.sv
// Backpressure generator: free-running pattern rotator and LFSR, with a
// mode select producing the request-ready flag.
module tcb_lite_sub_bpr
  import tcb_lite_pkg::*;
#(
  parameter logic [7:0]  PAT_INIT  = 8'b1011_0110,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic       rdy
);

  logic [7:0]  pat_reg;
  logic [15:0] lfsr_reg;
  logic        rdy_sel;

  // Both generators advance every cycle, so a mode change never disturbs their phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_reg  <= PAT_INIT;
      lfsr_reg <= LFSR_SEED;
    end else begin
      pat_reg  <= {pat_reg[0], pat_reg[7:1]};
      lfsr_reg <= lfsr_next(lfsr_reg);
    end
  end

  always_comb begin
    rdy_sel = 1'b0;
    case (bpr_mode_t'(mode))
      BPR_RDY:   rdy_sel = 1'b1;
      BPR_PAT:   rdy_sel = pat_reg[0];
      BPR_LFSR:  rdy_sel = lfsr_reg[0] | lfsr_reg[1];
      BPR_STALL: rdy_sel = 1'b0;
      default:   rdy_sel = 1'b0;
    endcase
  end

  // Held low while reset is asserted, whatever the mode.
  assign rdy = rst & rdy_sel;

endmodule

// File: rtl/tcb_lite_sub_mem.sv
// TCB-Lite subordinate: byte-addressed memory with fixed response delay,
// selectable backpressure, address error response and saturating statistics.
module tcb_lite_sub_mem #(
  parameter int          DLY       = 1,
  parameter int          ADR       = 32,
  parameter int          DAT       = 32,
  parameter int          SIZ       = 4096,
  parameter logic [7:0]  BPR_PAT   = 8'b1011_0110,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT       = 32,
  localparam int         BEN       = DAT/8
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           sub_vld,
  output logic           sub_rdy,
  input  logic           sub_wen,
  input  logic [ADR-1:0] sub_adr,
  input  logic [BEN-1:0] sub_ben,
  input  logic [DAT-1:0] sub_wdt,
  output logic [DAT-1:0] sub_rdt,
  output logic           sub_err,
  input  logic [1:0]     bpr_mode,
  input  logic           cnt_clr,
  output logic [CNT-1:0] cnt_trn,
  output logic [CNT-1:0] cnt_stl,
  output logic [CNT-1:0] cnt_idl
);

  import tcb_lite_pkg::*;

  localparam int ALB   = $clog2(BEN);
  localparam int AW    = $clog2(SIZ);
  localparam int WORDS = SIZ / BEN;
  localparam int IW    = (AW > ALB) ? (AW - ALB) : 1;

  logic              trn;
  logic              adr_err;
  logic              wr_en;
  logic [IW-1:0]     widx;
  logic [DAT-1:0]    mem [WORDS];
  tcb_lite_sub_rsp_t rsp_now;
  tcb_lite_sub_rsp_t rsp_out;
  logic              rsp_unused;
  logic [CNT-1:0]    cnt_reg [3];
  logic [2:0]        cnt_inc;

  tcb_lite_sub_bpr #(
    .PAT_INIT  (BPR_PAT),
    .LFSR_SEED (LFSR_SEED)
  ) u_bpr (
    .clk  (clk),
    .rst  (rst),
    .mode (bpr_mode),
    .rdy  (sub_rdy)
  );

  assign trn     = sub_vld & sub_rdy;
  assign adr_err = ((sub_adr >> AW) != '0) || ((sub_adr & ADR'(BEN - 1)) != '0);
  assign wr_en   = trn & sub_wen & ~adr_err;
  assign widx    = IW'(sub_adr >> ALB);

  // Contents survive reset on purpose: completed writes must persist.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BEN; i++) begin
        if (sub_ben[i]) mem[widx][8*i +: 8] <= sub_wdt[8*i +: 8];
      end
    end
  end

  // Non-transfer cycles and writes produce an all-zero response.
  always_comb begin
    rsp_now     = '0;
    rsp_now.err = trn & adr_err;
    if (trn && !sub_wen && !adr_err) rsp_now.rdt = RSP_DAT_MAX'(mem[widx]);
  end

  generate
    if (DLY == 0) begin : g_comb
      assign rsp_out = rsp_now;
    end else begin : g_pipe
      tcb_lite_sub_rsp_t rsp_reg [DLY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DLY; i++) rsp_reg[i] <= '0;
        end else begin
          rsp_reg[0] <= rsp_now;
          for (int i = 1; i < DLY; i++) rsp_reg[i] <= rsp_reg[i-1];
        end
      end

      assign rsp_out = rsp_reg[DLY-1];
    end
  endgenerate

  assign sub_rdt    = rsp_out.rdt[DAT-1:0];
  assign sub_err    = rsp_out.err;
  assign rsp_unused = |(rsp_out.rdt >> DAT);

  // Index 0: transfers, 1: stalls, 2: idles; exactly one is set each cycle.
  assign cnt_inc = {~sub_vld, sub_vld & ~sub_rdy, trn};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr) begin
          cnt_reg[i] <= '0;
        end else if (cnt_inc[i] && (cnt_reg[i] != '1)) begin
          cnt_reg[i] <= cnt_reg[i] + CNT'(1);
        end
      end
    end
  end

  assign cnt_trn = cnt_reg[0];
  assign cnt_stl = cnt_reg[1];
  assign cnt_idl = cnt_reg[2];

endmodule

// File: tb/tb_tcb_lite_sub_mem.sv
// Bench for tcb_lite_sub_mem: three builds (DLY 0/1/3, the DLY=3 one with 4-bit
// counters) share one request stream and are checked against a byte-level model.
module tb_tcb_lite_sub_mem;

  localparam logic [7:0]  PAT  = 8'b1011_0110;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        sub_vld  = 1'b0;
  logic        sub_wen  = 1'b0;
  logic        cnt_clr  = 1'b0;
  logic [31:0] sub_adr  = '0;
  logic [31:0] sub_wdt  = '0;
  logic [3:0]  sub_ben  = '0;
  logic [1:0]  bpr_mode = '0;

  logic        rdy_d0, rdy_d1, rdy_d3;
  logic        err_d0, err_d1, err_d3;
  logic [31:0] rdt_d0, rdt_d1, rdt_d3;
  logic [31:0] trn_d0, stl_d0, idl_d0, trn_d1, stl_d1, idl_d1;
  logic [3:0]  trn_d3, stl_d3, idl_d3;

  always #5 clk = ~clk;

  tcb_lite_sub_mem #(.DLY(0)) u_d0 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_d0), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(rdt_d0),
    .sub_err(err_d0), .bpr_mode(bpr_mode), .cnt_clr(cnt_clr),
    .cnt_trn(trn_d0), .cnt_stl(stl_d0), .cnt_idl(idl_d0));

  tcb_lite_sub_mem u_d1 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_d1), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(rdt_d1),
    .sub_err(err_d1), .bpr_mode(bpr_mode), .cnt_clr(cnt_clr),
    .cnt_trn(trn_d1), .cnt_stl(stl_d1), .cnt_idl(idl_d1));

  tcb_lite_sub_mem #(.DLY(3), .CNT(4)) u_d3 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_d3), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(rdt_d3),
    .sub_err(err_d3), .bpr_mode(bpr_mode), .cnt_clr(cnt_clr),
    .cnt_trn(trn_d3), .cnt_stl(stl_d3), .cnt_idl(idl_d3));

  // Reference model state
  logic [7:0]  m_mem [4096];
  int          m_cyc;
  logic [15:0] m_lfsr;
  logic [31:0] h_rdt [4];
  logic        h_err [4];
  int          c_trn, c_stl, c_idl;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic exp_rdy();
    logic [7:0] p;
    p = PAT;
    if (!rst) return 1'b0;
    case (bpr_mode)
      2'd0:    return 1'b1;
      2'd1:    return p[m_cyc % 8];
      2'd2:    return m_lfsr[0] | m_lfsr[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {m_mem[b + 12'd3], m_mem[b + 12'd2], m_mem[b + 12'd1], m_mem[b]};
  endfunction

  function automatic logic [3:0] sat4(input int c);
    return (c > 15) ? 4'hF : c[3:0];
  endfunction

  // One clock cycle: check every output at the falling edge, then step the model.
  task automatic tick();
    logic        r, trn, bad;
    logic [31:0] rd;
    @(negedge clk);
    r = exp_rdy();
    chk("rdy_d0", rdy_d0, r);
    chk("rdy_d1", rdy_d1, r);
    chk("rdy_d3", rdy_d3, r);
    chk("cnt_trn_d1", trn_d1, c_trn);
    chk("cnt_stl_d1", stl_d1, c_stl);
    chk("cnt_idl_d1", idl_d1, c_idl);
    chk("cnt_trn_d0", trn_d0, c_trn);
    chk("cnt_stl_d0", stl_d0, c_stl);
    chk("cnt_idl_d0", idl_d0, c_idl);
    chk("cnt_trn_d3", trn_d3, sat4(c_trn));
    chk("cnt_stl_d3", stl_d3, sat4(c_stl));
    chk("cnt_idl_d3", idl_d3, sat4(c_idl));
    trn = sub_vld && r;
    bad = (sub_adr >= 32'd4096) || (sub_adr[1:0] != 2'b00);
    rd  = (trn && !sub_wen && !bad) ? m_word(sub_adr) : 32'h0;
    if (rst) begin
      for (int i = 3; i > 0; i--) begin
        h_rdt[i] = h_rdt[i-1];
        h_err[i] = h_err[i-1];
      end
      h_rdt[0] = rd;
      h_err[0] = trn && bad;
    end
    chk("rdt_d0", rdt_d0, h_rdt[0]);
    chk("err_d0", err_d0, h_err[0]);
    chk("rdt_d1", rdt_d1, h_rdt[1]);
    chk("err_d1", err_d1, h_err[1]);
    chk("rdt_d3", rdt_d3, h_rdt[3]);
    chk("err_d3", err_d3, h_err[3]);
    if (trn)
      $display("trn %s adr=%h ben=%h wdt=%h err=%0d rdt=%h",
               sub_wen ? "wr" : "rd", sub_adr, sub_ben, sub_wdt, bad, rd);
    if (rst) begin
      if (trn && sub_wen && !bad)
        for (int i = 0; i < 4; i++)
          if (sub_ben[i]) m_mem[sub_adr[11:0] + 12'(i)] = sub_wdt[8*i +: 8];
      if (cnt_clr) begin
        c_trn = 0; c_stl = 0; c_idl = 0;
      end else if (!sub_vld) c_idl++;
      else if (r) c_trn++;
      else c_stl++;
      m_cyc++;
      m_lfsr = lfsr_step(m_lfsr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_rdy_d1", rdy_d1, 1'b0);
    chk("rst_rdt_d1", rdt_d1, 32'h0);
    chk("rst_err_d1", err_d1, 1'b0);
    chk("rst_rdt_d3", rdt_d3, 32'h0);
    chk("rst_err_d3", err_d3, 1'b0);
    chk("rst_cnt_trn", trn_d1, 32'h0);
    chk("rst_cnt_stl_d3", stl_d3, 4'h0);
    for (int i = 0; i < 4; i++) begin
      h_rdt[i] = '0;
      h_err[i] = 1'b0;
    end
    c_trn = 0; c_stl = 0; c_idl = 0;
    m_cyc = 0;
    m_lfsr = SEED;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic issue(input logic wen, input logic [31:0] adr, input logic [3:0] ben,
                       input logic [31:0] wdt);
    sub_vld = 1'b1; sub_wen = wen; sub_adr = adr; sub_ben = ben; sub_wdt = wdt;
    tick();
  endtask

  task automatic idle();
    sub_vld = 1'b0;
    tick();
  endtask

  initial begin
    logic [0:7] seq;
    #2;
    do_reset();
    bpr_mode = 2'd0;

    // Give every word a known value so any later read is predictable.
    for (int w = 0; w < 1024; w++) issue(1'b1, 32'(w * 4), 4'hF, $urandom());
    idle();

    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    chk("rd_0x10", rdt_d1, 32'hDEADBEEF);
    chk("rd_0x10_err", err_d1, 1'b0);
    idle();

    issue(1'b1, 32'h20, 4'hF, 32'hDEADBEEF);
    issue(1'b1, 32'h20, 4'b0101, 32'h11223344);
    issue(1'b0, 32'h20, 4'hF, 32'h0);
    chk("partial_wr", rdt_d1, 32'hDE22BE44);
    idle();

    issue(1'b0, 32'h1000, 4'hF, 32'h0);
    chk("oor_rd_err", err_d1, 1'b1);
    chk("oor_rd_rdt", rdt_d1, 32'h0);
    issue(1'b1, 32'h22, 4'hF, 32'hCAFEF00D);
    chk("mis_wr_err", err_d1, 1'b1);
    issue(1'b0, 32'h22, 4'hF, 32'h0);
    chk("mis_rd_err", err_d1, 1'b1);
    chk("mis_rd_rdt", rdt_d1, 32'h0);
    issue(1'b0, 32'h20, 4'hF, 32'h0);
    chk("mis_wr_nochg", rdt_d1, 32'hDE22BE44);
    issue(1'b0, 32'h24, 4'hF, 32'h0);
    idle();

    // Randomised traffic across the ready, pattern and LFSR modes.
    for (int k = 0; k < 800; k++) begin
      if (k % 100 == 0) bpr_mode = 2'($urandom_range(0, 2));
      sub_vld = ($urandom_range(0, 3) != 0);
      sub_wen = 1'($urandom_range(0, 1));
      sub_adr = 32'($urandom_range(0, 1023) * 4);
      case ($urandom_range(0, 15))
        0:       sub_adr = sub_adr + 32'($urandom_range(1, 3));
        1:       sub_adr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        2:       sub_adr = $urandom();
        default: ;
      endcase
      sub_ben = 4'($urandom());
      sub_wdt = $urandom();
      cnt_clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    sub_vld = 1'b0;
    cnt_clr = 1'b0;
    idle();

    // Pattern mode straight out of reset; reads here also show writes survived reset.
    do_reset();
    bpr_mode = 2'd1;
    seq = 8'b0110_1101;
    sub_vld = 1'b1; sub_wen = 1'b0; sub_adr = 32'h40; sub_ben = 4'hF;
    for (int i = 0; i < 16; i++) begin
      chk("pat_seq", rdy_d1, seq[i % 8]);
      tick();
    end
    sub_vld = 1'b0;
    chk("pat_cnt_trn", trn_d1, 32'd10);
    chk("pat_cnt_stl", stl_d1, 32'd6);
    chk("pat_cnt_idl", idl_d1, 32'd0);

    // Never-ready mode, counter clear and saturation of the 4-bit counters.
    bpr_mode = 2'd3;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    sub_vld = 1'b1;
    repeat (5) tick();
    sub_vld = 1'b0;
    repeat (3) tick();
    chk("stall_cnt_stl", stl_d1, 32'd5);
    chk("stall_cnt_idl", idl_d1, 32'd3);
    chk("stall_cnt_trn", trn_d1, 32'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt_trn", trn_d1, 32'd0);
    chk("clr_cnt_stl", stl_d1, 32'd0);
    chk("clr_cnt_idl", idl_d1, 32'd0);
    sub_vld = 1'b1;
    repeat (20) tick();
    sub_vld = 1'b0;
    chk("sat_stl_d3", stl_d3, 4'hF);
    chk("nosat_stl_d1", stl_d1, 32'd20);

    // Back-to-back reads on the DLY=3 build, then reset with responses in flight.
    do_reset();
    bpr_mode = 2'd0;
    issue(1'b0, 32'h0, 4'hF, 32'h0);
    issue(1'b0, 32'h4, 4'hF, 32'h0);
    issue(1'b0, 32'h8, 4'hF, 32'h0);
    issue(1'b0, 32'hC, 4'hF, 32'h0);
    chk("burst_d3_1", rdt_d3, m_word(32'h4));
    idle();
    chk("burst_d3_2", rdt_d3, m_word(32'h8));
    do_reset();
    repeat (6) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
